// File: rtl/succ_req_issuer.sv
// succ_req_issuer
//   Walks one source node's successor list in successor memory and issues the
//   successors as 8-lane request beats toward the node filter bank. Each valid
//   lane carries the source node's path count and one successor node number.
//   Lanes that do not carry a request always drive nodenum=12'hFFT-reserved
//   pattern (12'hFFF) with paths=0, because filters match on nodenum alone.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               start pulse, honoured only while idle
//   i_src_paths           path count of the source node
//   i_succ_base           address of the first successor entry
//   i_succ_count          number of successor entries
//   o_busy                high while a list is being processed (incl. done cycle)
//   o_done                one-cycle pulse after the last beat is accepted
//   o_mem_rd_en/o_mem_addr  successor-memory read port (data returns next cycle)
//   i_mem_rdata           successor node number
//   o_req_vld             per-lane valid of the current beat (nonzero only in SEND)
//   o_req_paths           per-lane path payload
//   o_req_nodenum         per-lane destination node number
//   i_req_rdy             downstream accepts the beat
module succ_req_issuer #(
    parameter int PAYLOAD_WIDTH = 16,
    parameter int ADDR_WIDTH    = 12,
    parameter int CNT_WIDTH     = 6
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic [PAYLOAD_WIDTH-1:0]      i_src_paths,
    input  logic [ADDR_WIDTH-1:0]         i_succ_base,
    input  logic [CNT_WIDTH-1:0]          i_succ_count,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0]         o_mem_addr,
    input  logic [11:0]                   i_mem_rdata,
    output logic [7:0]                    o_req_vld,
    output logic [7:0][PAYLOAD_WIDTH-1:0] o_req_paths,
    output logic [7:0][11:0]              o_req_nodenum,
    input  logic                          i_req_rdy
);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, SEND, FIN} state_t;

    state_t                          state;
    state_t                          state_nxt;

    logic [PAYLOAD_WIDTH-1:0]        paths_q;
    logic [ADDR_WIDTH-1:0]           cursor;
    logic [CNT_WIDTH-1:0]            remaining;
    logic [2:0]                      lane_idx;   // slot the next read fills
    logic                            rd_pend;    // a read was issued last cycle
    logic [2:0]                      pend_slot;  // slot that read belongs to

    logic [7:0]                      beat_vld;
    logic [7:0][11:0]                beat_node;
    logic [7:0][PAYLOAD_WIDTH-1:0]   beat_paths;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (i_start) state_nxt = (i_succ_count == '0) ? FIN : FETCH;
            // Stop after the 8th slot of the beat or the last list entry.
            FETCH: if (lane_idx == 3'd7 || remaining == CNT_WIDTH'(1)) state_nxt = DRAIN;
            DRAIN: state_nxt = SEND;
            SEND:  if (i_req_rdy) state_nxt = (remaining != '0) ? FETCH : FIN;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: list cursor, read pipeline and beat registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            paths_q    <= '0;
            cursor     <= '0;
            remaining  <= '0;
            lane_idx   <= '0;
            rd_pend    <= 1'b0;
            pend_slot  <= '0;
            beat_vld   <= '0;
            beat_node  <= '1;
            beat_paths <= '0;
        end else begin
            rd_pend   <= (state == FETCH);
            pend_slot <= lane_idx;

            case (state)
                IDLE: begin
                    if (i_start) begin
                        paths_q   <= i_src_paths;
                        cursor    <= i_succ_base;
                        remaining <= i_succ_count;
                        lane_idx  <= '0;
                    end
                end
                FETCH: begin
                    cursor    <= cursor + ADDR_WIDTH'(1);
                    remaining <= remaining - CNT_WIDTH'(1);
                    lane_idx  <= lane_idx + 3'd1;
                end
                SEND: begin
                    if (i_req_rdy) begin
                        beat_vld   <= '0;
                        beat_node  <= '1;
                        beat_paths <= '0;
                        lane_idx   <= '0;
                    end
                end
                default: ;
            endcase

            // Read data lands one cycle after its strobe; never overlaps SEND.
            if (rd_pend) begin
                beat_vld[pend_slot]   <= 1'b1;
                beat_node[pend_slot]  <= i_mem_rdata;
                beat_paths[pend_slot] <= paths_q;
            end
        end
    end

    // Outputs
    always_comb begin
        o_busy      = (state != IDLE);
        o_done      = (state == FIN);
        o_mem_rd_en = (state == FETCH);
        o_mem_addr  = cursor;
        o_req_vld   = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            o_req_nodenum[k] = '1;
            o_req_paths[k]   = '0;
            // Partially filled lanes stay hidden until the beat is complete.
            if (state == SEND && beat_vld[k]) begin
                o_req_nodenum[k] = beat_node[k];
                o_req_paths[k]   = beat_paths[k];
            end
        end
        if (state == SEND) o_req_vld = beat_vld;
    end

endmodule

// File: tb/tb_succ_req_issuer.sv
module tb_succ_req_issuer;

    localparam logic [7:0][11:0] NODE_IDLE  = {8{12'hFFF}};
    localparam logic [7:0][15:0] PATHS_IDLE = '0;

    logic              clk = 1'b0;
    logic              i_rst;
    logic              i_start;
    logic [15:0]       i_src_paths;
    logic [11:0]       i_succ_base;
    logic [5:0]        i_succ_count;
    logic              o_busy;
    logic              o_done;
    logic              o_mem_rd_en;
    logic [11:0]       o_mem_addr;
    logic [11:0]       i_mem_rdata;
    logic [7:0]        o_req_vld;
    logic [7:0][15:0]  o_req_paths;
    logic [7:0][11:0]  o_req_nodenum;
    logic              i_req_rdy;

    always #5 clk = ~clk;

    succ_req_issuer #(
        .PAYLOAD_WIDTH(16),
        .ADDR_WIDTH   (12),
        .CNT_WIDTH    (6)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_src_paths  (i_src_paths),
        .i_succ_base  (i_succ_base),
        .i_succ_count (i_succ_count),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_mem_rd_en  (o_mem_rd_en),
        .o_mem_addr   (o_mem_addr),
        .i_mem_rdata  (i_mem_rdata),
        .o_req_vld    (o_req_vld),
        .o_req_paths  (o_req_paths),
        .o_req_nodenum(o_req_nodenum),
        .i_req_rdy    (i_req_rdy)
    );

    // Successor memory model: data valid the cycle after the strobe
    logic [11:0] mem [0:4095];
    always @(posedge clk) begin
        if (o_mem_rd_en) i_mem_rdata <= mem[o_mem_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic             start;
        logic             rdy;
        logic [15:0]      paths;
        logic [11:0]      base;
        logic [5:0]       cnt;
        logic             busy;
        logic             done;
        logic             rd;
        logic             chk_addr;
        logic [11:0]      addr;
        logic [7:0]       vld;
        logic [7:0][11:0] node;
        logic [7:0][15:0] lpaths;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input logic start, input logic rdy, input logic [15:0] paths,
                                 input logic [11:0] base, input logic [5:0] cnt,
                                 input logic busy, input logic done, input logic rd,
                                 input logic ca, input logic [11:0] addr, input logic [7:0] vld,
                                 input logic [7:0][11:0] node, input logic [7:0][15:0] lp);
        vec_t v;
        v.start = start; v.rdy = rdy; v.paths = paths; v.base = base; v.cnt = cnt;
        v.busy = busy; v.done = done; v.rd = rd; v.chk_addr = ca; v.addr = addr;
        v.vld = vld; v.node = node; v.lpaths = lp;
        return v;
    endfunction

    // Results collected by run()
    logic [11:0]      got_addr[$];
    logic [7:0]       got_vld[$];
    logic [7:0][11:0] got_node[$];
    logic [7:0][15:0] got_paths[$];
    int               done_cnt;
    int               first_send;

    task automatic run(input logic [15:0] paths, input logic [11:0] base, input logic [5:0] cnt,
                       input int stall, input int mid_start, input int rst_at, input int budget);
        int               done_cyc;
        int               sc;
        int               beat_idx;
        bit               finished;
        logic [7:0]       s_vld;
        logic [7:0][11:0] s_node;
        logic [7:0][15:0] s_paths;
        got_addr.delete(); got_vld.delete(); got_node.delete(); got_paths.delete();
        done_cnt = 0; first_send = -1; done_cyc = -1; sc = 0; beat_idx = 0; finished = 0;
        s_vld = '0; s_node = NODE_IDLE; s_paths = '0;
        @(negedge clk);
        i_start = 1'b1; i_src_paths = paths; i_succ_base = base; i_succ_count = cnt;
        i_req_rdy = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (cyc == mid_start) begin
                i_start = 1'b1; i_src_paths = 16'h1111; i_succ_base = 12'h300; i_succ_count = 6'd5;
            end
            if (rst_at > 0 && cyc == rst_at + 1) begin
                chk("rst_vld",   o_req_vld, 8'h00);
                chk("rst_busy",  o_busy, 1'b0);
                chk("rst_done",  o_done, 1'b0);
                chk("rst_rd_en", o_mem_rd_en, 1'b0);
                chk("rst_addr",  o_mem_addr, 12'h000);
                chk("rst_node",  o_req_nodenum, NODE_IDLE);
                chk("rst_paths", o_req_paths, PATHS_IDLE);
                i_rst = 1'b0;
                finished = 1;
                break;
            end
            if (cyc == rst_at) i_rst = 1'b1;
            if (o_mem_rd_en) got_addr.push_back(o_mem_addr);
            if (o_done) begin done_cnt++; done_cyc = cyc; end
            if (o_req_vld != 8'h00) begin
                if (first_send < 0) first_send = cyc;
                if (beat_idx == 0 && sc < stall) begin
                    i_req_rdy = 1'b0;
                    if (sc == 0) begin
                        s_vld = o_req_vld; s_node = o_req_nodenum; s_paths = o_req_paths;
                    end else begin
                        chk($sformatf("stall%0d_vld", sc),   o_req_vld, s_vld);
                        chk($sformatf("stall%0d_node", sc),  o_req_nodenum, s_node);
                        chk($sformatf("stall%0d_paths", sc), o_req_paths, s_paths);
                    end
                    sc++;
                end else begin
                    if (beat_idx == 0 && stall > 0) begin
                        chk("accept_vld_stable",  o_req_vld, s_vld);
                        chk("accept_node_stable", o_req_nodenum, s_node);
                    end
                    i_req_rdy = 1'b1;
                    got_vld.push_back(o_req_vld);
                    got_node.push_back(o_req_nodenum);
                    got_paths.push_back(o_req_paths);
                    beat_idx++;
                end
            end else begin
                i_req_rdy = 1'b1;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                chk("busy_after_done", o_busy, 1'b0);
                finished = 1;
                break;
            end
        end
        if (!finished) chk("run_timeout", 1'b0, 1'b1);
        i_start = 1'b0;
        i_req_rdy = 1'b0;
        i_rst = 1'b0;
    endtask

    task automatic check_beats(input logic [15:0] paths, input logic [11:0] base, input int cnt);
        int               nb;
        int               n;
        logic [7:0]       ev;
        logic [7:0][11:0] en;
        logic [7:0][15:0] ep;
        nb = (cnt + 7) / 8;
        chk("addr_count", got_addr.size(), cnt);
        for (int i = 0; i < cnt && i < got_addr.size(); i++)
            chk($sformatf("addr%0d", i), got_addr[i], 12'(base + i));
        chk("beat_count", got_vld.size(), nb);
        for (int b = 0; b < nb && b < got_vld.size(); b++) begin
            n  = (cnt - 8 * b > 8) ? 8 : cnt - 8 * b;
            ev = '0; en = NODE_IDLE; ep = '0;
            for (int l = 0; l < n; l++) begin
                ev[l] = 1'b1;
                en[l] = mem[12'(base + 8 * b + l)];
                ep[l] = paths;
            end
            chk($sformatf("beat%0d_vld", b),   got_vld[b], ev);
            chk($sformatf("beat%0d_node", b),  got_node[b], en);
            chk($sformatf("beat%0d_paths", b), got_paths[b], ep);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0][11:0] node_a;
        logic [7:0][15:0] paths_a;

        for (int i = 0; i < 4096; i++) begin
            mem[i] = 12'((i * 7 + 3) % 4096);
            if (mem[i] == 12'hFFF) mem[i] = 12'h000;
        end
        mem[12'h010] = 12'd5; mem[12'h011] = 12'd9; mem[12'h012] = 12'd2;

        i_rst = 1'b1; i_start = 1'b0; i_src_paths = '0; i_succ_base = '0;
        i_succ_count = '0; i_req_rdy = 1'b0; i_mem_rdata = '0;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;

        node_a  = {{5{12'hFFF}}, 12'd2, 12'd9, 12'd5};
        paths_a = {{5{16'h0000}}, 16'd7, 16'd7, 16'd7};

        // Idle after reset
        for (int i = 0; i < 5; i++)
            vecs.push_back(mkv(0, 0, 16'd7, 12'h010, 6'd3, 0, 0, 0, 1, 12'h000, 8'h00, NODE_IDLE, PATHS_IDLE));
        // count=3 run, rdy high in SEND
        vecs.push_back(mkv(1, 0, 16'd7, 12'h010, 6'd3, 0, 0, 0, 1, 12'h000, 8'h00, NODE_IDLE, PATHS_IDLE));
        vecs.push_back(mkv(0, 0, 16'd7, 12'h010, 6'd3, 1, 0, 1, 1, 12'h010, 8'h00, NODE_IDLE, PATHS_IDLE));
        vecs.push_back(mkv(0, 0, 16'd7, 12'h010, 6'd3, 1, 0, 1, 1, 12'h011, 8'h00, NODE_IDLE, PATHS_IDLE));
        vecs.push_back(mkv(0, 0, 16'd7, 12'h010, 6'd3, 1, 0, 1, 1, 12'h012, 8'h00, NODE_IDLE, PATHS_IDLE));
        vecs.push_back(mkv(0, 0, 16'd7, 12'h010, 6'd3, 1, 0, 0, 0, 12'h000, 8'h00, NODE_IDLE, PATHS_IDLE));
        vecs.push_back(mkv(0, 1, 16'd7, 12'h010, 6'd3, 1, 0, 0, 0, 12'h000, 8'h07, node_a, paths_a));
        vecs.push_back(mkv(0, 0, 16'd7, 12'h010, 6'd3, 1, 1, 0, 0, 12'h000, 8'h00, NODE_IDLE, PATHS_IDLE));
        vecs.push_back(mkv(0, 0, 16'd7, 12'h010, 6'd3, 0, 0, 0, 0, 12'h000, 8'h00, NODE_IDLE, PATHS_IDLE));
        // count=0 run: straight to done, no reads
        vecs.push_back(mkv(1, 1, 16'd9, 12'h050, 6'd0, 0, 0, 0, 0, 12'h000, 8'h00, NODE_IDLE, PATHS_IDLE));
        vecs.push_back(mkv(0, 1, 16'd9, 12'h050, 6'd0, 1, 1, 0, 1, 12'h050, 8'h00, NODE_IDLE, PATHS_IDLE));
        vecs.push_back(mkv(0, 0, 16'd9, 12'h050, 6'd0, 0, 0, 0, 1, 12'h050, 8'h00, NODE_IDLE, PATHS_IDLE));

        foreach (vecs[i]) begin
            @(negedge clk);
            chk($sformatf("v%0d_busy", i),  o_busy, vecs[i].busy);
            chk($sformatf("v%0d_done", i),  o_done, vecs[i].done);
            chk($sformatf("v%0d_rd_en", i), o_mem_rd_en, vecs[i].rd);
            if (vecs[i].chk_addr) chk($sformatf("v%0d_addr", i), o_mem_addr, vecs[i].addr);
            chk($sformatf("v%0d_vld", i),   o_req_vld, vecs[i].vld);
            chk($sformatf("v%0d_node", i),  o_req_nodenum, vecs[i].node);
            chk($sformatf("v%0d_paths", i), o_req_paths, vecs[i].lpaths);
            i_start = vecs[i].start; i_req_rdy = vecs[i].rdy; i_src_paths = vecs[i].paths;
            i_succ_base = vecs[i].base; i_succ_count = vecs[i].cnt;
        end

        // count=11 with a 4-cycle stall on the first beat
        run(16'hABCD, 12'h100, 6'd11, 4, -1, -1, 60);
        check_beats(16'hABCD, 12'h100, 11);
        chk("c11_done_cnt", done_cnt, 1);
        chk("c11_first_send", first_send, 10);

        // Address wrap
        run(16'h0042, 12'hFFE, 6'd4, 0, -1, -1, 30);
        check_beats(16'h0042, 12'hFFE, 4);
        chk("wrap_first_send", first_send, 6);
        chk("wrap_done_cnt", done_cnt, 1);

        // Reset during the second fetch of a count=12 run
        run(16'h0022, 12'h200, 6'd12, 0, -1, 12, 40);
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_beats", got_vld.size(), 1);

        // Fresh run after reset, with a start pulse while busy
        run(16'd7, 12'h010, 6'd3, 0, 2, -1, 30);
        check_beats(16'd7, 12'h010, 3);
        chk("fresh_first_send", first_send, 5);
        chk("fresh_done_cnt", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
